// File: rtl/dmem_cache.sv
// dmem_cache: direct-mapped, write-through, no-write-allocate data cache.
// One-word lines. Read hits return data one cycle after sampling with no
// stall; read misses and every write freeze the core via `stall` until the
// backing memory has serviced them.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   dcache_addr         word-aligned byte address (bits [1:0] ignored)
//   dcache_re           read request
//   dcache_we           byte write enables (nonzero = write request)
//   dcache_din          store data, byte-lane aligned
//   dcache_dout         load data
//   stall               core must freeze and hold its request while high
//   mem_req_valid/ready backing-memory request handshake
//   mem_req_rw          1 = write, 0 = read
//   mem_req_addr        word address
//   mem_req_data        write data
//   mem_req_mask        byte mask (0 on reads)
//   mem_resp_valid      read data valid (one-cycle pulse)
//   mem_resp_data       read data
module dmem_cache #(
  parameter int LINES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] dcache_addr,
  input  logic        dcache_re,
  input  logic [3:0]  dcache_we,
  input  logic [31:0] dcache_din,
  output logic [31:0] dcache_dout,
  output logic        stall,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_rw,
  output logic [29:0] mem_req_addr,
  output logic [31:0] mem_req_data,
  output logic [3:0]  mem_req_mask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    READ_REQ,
    READ_WAIT,
    WRITE_REQ,
    RESP
  } state_t;

  state_t state, state_next;

  logic [31:2]      req_addr;
  logic [3:0]       req_we;
  logic [31:0]      req_din;
  logic             req_rd;
  logic [31:0]      out_reg;
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             hit;
  logic             is_write;
  logic             is_read;
  logic             lookup_hit;
  logic             sample;
  logic             fill;
  logic             write_merge;
  logic             addr_lsb_unused;

  assign addr_lsb_unused = ^dcache_addr[1:0];

  assign idx        = req_addr[IDX_W+1:2];
  assign tag        = req_addr[31:IDX_W+2];
  assign hit        = valid[idx] && (tag_mem[idx] == tag);
  // A request with both read and write asserted is handled as a write.
  assign is_write   = |req_we;
  assign is_read    = req_rd && !is_write;
  assign lookup_hit = (state == LOOKUP) && is_read && hit;
  assign fill       = (state == READ_WAIT) && mem_resp_valid;
  assign write_merge = (state == WRITE_REQ) && mem_req_ready && hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Outputs are resolved first so that `sample` (which depends on `stall`)
  // can feed the next-state decision within the same block.
  always_comb begin
    stall         = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_rw    = 1'b0;
    mem_req_mask  = '0;
    dcache_dout   = out_reg;
    state_next    = state;

    unique case (state)
      LOOKUP: begin
        if (lookup_hit) dcache_dout = data_mem[idx];
        else            stall = 1'b1;
      end
      READ_REQ: begin
        stall         = 1'b1;
        mem_req_valid = 1'b1;
      end
      READ_WAIT: stall = 1'b1;
      WRITE_REQ: begin
        stall         = 1'b1;
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b1;
        mem_req_mask  = req_we;
      end
      default: ;
    endcase

    sample = !stall && (dcache_re || (dcache_we != '0));

    unique case (state)
      IDLE:      if (sample) state_next = LOOKUP;
      LOOKUP: begin
        if (is_write) state_next = WRITE_REQ;
        else if (hit) state_next = sample ? LOOKUP : IDLE;
        else          state_next = READ_REQ;
      end
      READ_REQ:  if (mem_req_ready) state_next = READ_WAIT;
      READ_WAIT: if (mem_resp_valid) state_next = RESP;
      WRITE_REQ: if (mem_req_ready) state_next = RESP;
      RESP:      state_next = sample ? LOOKUP : IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_addr     <= '0;
      req_we       <= '0;
      req_din      <= '0;
      req_rd       <= 1'b0;
      out_reg      <= '0;
      valid        <= '0;
      mem_req_addr <= '0;
      mem_req_data <= '0;
    end else begin
      if (sample) begin
        req_addr <= dcache_addr[31:2];
        req_we   <= dcache_we;
        req_din  <= dcache_din;
        req_rd   <= dcache_re;
      end
      if (state == LOOKUP) begin
        if (lookup_hit) begin
          out_reg <= data_mem[idx];
        end else begin
          // Request fields are latched once and held through the handshake.
          mem_req_addr <= req_addr;
          mem_req_data <= req_din;
        end
      end
      if (fill) begin
        valid[idx] <= 1'b1;
        out_reg    <= mem_resp_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= mem_resp_data;
    end else if (write_merge) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (req_we[b]) data_mem[idx][8*b +: 8] <= req_din[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_dmem_cache.sv
module tb_dmem_cache;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] dcache_addr;
  logic        dcache_re;
  logic [3:0]  dcache_we;
  logic [31:0] dcache_din;
  logic [31:0] dcache_dout;
  logic        stall;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_rw;
  logic [29:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [3:0]  mem_req_mask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  always #5 clk = ~clk;

  dmem_cache #(.LINES(64)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .dcache_addr   (dcache_addr),
    .dcache_re     (dcache_re),
    .dcache_we     (dcache_we),
    .dcache_din    (dcache_din),
    .dcache_dout   (dcache_dout),
    .stall         (stall),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_rw    (mem_req_rw),
    .mem_req_addr  (mem_req_addr),
    .mem_req_data  (mem_req_data),
    .mem_req_mask  (mem_req_mask),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data)
  );

  typedef struct {
    bit          is_write;
    logic [29:0] waddr;
    logic [31:0] data;
    logic [3:0]  mask;
    int          hs;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: memory contents as the core sees them, and which word
  // address currently occupies each cache index.
  logic [31:0] ref_mem  [int unsigned];
  logic [29:0] ref_line [int unsigned];
  // Backing store owned by the memory responder, updated only by DUT writes.
  logic [31:0] back_mem [int unsigned];

  function automatic logic [31:0] init_word(input logic [29:0] w);
    return ({2'b00, w} * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [29:0] w);
    return ref_mem.exists(int'(w)) ? ref_mem[int'(w)] : init_word(w);
  endfunction

  function automatic logic [31:0] back_rd(input logic [29:0] w);
    return back_mem.exists(int'(w)) ? back_mem[int'(w)] : init_word(w);
  endfunction

  // ---------------- memory responder ----------------
  int delay_min = 0, delay_max = 0, lat_min = 1, lat_max = 1;
  int cur_delay = 0, wait_cnt = 0, hs_count = 0, resp_wait = 0;
  bit hs_seen = 0, resp_active = 0, held_prev = 0;
  logic        cap_rw, last_rw, prev_rw;
  logic [29:0] cap_addr, last_addr, prev_addr, resp_addr;
  logic [31:0] cap_data, last_data, prev_data;
  logic [3:0]  cap_mask, last_mask, prev_mask;

  initial begin
    forever begin
      @(negedge clk);
      hs_seen = reset_n && mem_req_valid && mem_req_ready;
      cap_rw = mem_req_rw; cap_addr = mem_req_addr;
      cap_data = mem_req_data; cap_mask = mem_req_mask;
      if (reset_n && mem_req_valid && held_prev) begin
        chk("req_stable_ctl", {prev_rw, prev_mask, prev_addr}, {mem_req_rw, mem_req_mask, mem_req_addr});
        chk("req_stable_data", prev_data, mem_req_data);
      end
      held_prev = reset_n && mem_req_valid && !mem_req_ready;
      prev_rw = mem_req_rw; prev_addr = mem_req_addr;
      prev_data = mem_req_data; prev_mask = mem_req_mask;
    end
  end

  initial begin
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    forever begin
      @(posedge clk); #1;
      mem_resp_valid = 1'b0;
      if (hs_seen) begin
        hs_seen = 0;
        hs_count++;
        last_rw = cap_rw; last_addr = cap_addr; last_data = cap_data; last_mask = cap_mask;
        if (cap_rw) begin
          logic [31:0] m;
          m = back_rd(cap_addr);
          for (int b = 0; b < 4; b++) if (cap_mask[b]) m[8*b +: 8] = cap_data[8*b +: 8];
          back_mem[int'(cap_addr)] = m;
        end else begin
          resp_active = 1;
          resp_addr = cap_addr;
          resp_wait = int'($urandom_range(lat_max, lat_min)) - 1;
        end
        wait_cnt = 0;
      end else if (mem_req_valid) begin
        if (wait_cnt == 0) cur_delay = int'($urandom_range(delay_max, delay_min));
        wait_cnt++;
      end
      if (resp_active) begin
        if (resp_wait == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_data = back_rd(resp_addr);
          resp_active = 0;
        end else begin
          resp_wait--;
        end
      end
      mem_req_ready = (wait_cnt > cur_delay);
    end
  end

  // ---------------- monitor ----------------
  initial begin
    bit outstanding = 0;
    int lat = 0, base = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        outstanding = 0;
        continue;
      end
      if (outstanding) begin
        lat++;
        if (!stall) begin
          outstanding = 0;
          if (sb.size() == 0) begin
            chk("sb_underflow", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("mem_req_count", hs_count - base, e.hs);
            if (e.hs == 1) begin
              chk("mem_req_rw", last_rw, e.is_write);
              chk("mem_req_addr", last_addr, e.waddr);
              if (e.is_write) begin
                chk("mem_req_data", last_data, e.data);
                chk("mem_req_mask", last_mask, e.mask);
              end
            end
            if (!e.is_write) begin
              chk("load_data", dcache_dout, e.data);
              if (e.hs == 0) chk("hit_latency", lat, 1);
              else           chk("miss_stalled", lat >= 3, 1);
            end
          end
        end else if (lat > 300) begin
          chk("completion_timeout", lat, 0);
          outstanding = 0;
        end
      end
      if (!stall && (dcache_re || dcache_we != '0)) begin
        outstanding = 1;
        lat = 0;
        base = hs_count;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input bit rd, input logic [3:0] we, input logic [31:0] addr, input logic [31:0] din);
    exp_t e;
    logic [29:0] w;
    logic [31:0] m;
    int unsigned idx;
    int cyc;
    w = addr[31:2];
    idx = int'(w) % 64;
    e.waddr = w; e.mask = we; e.is_write = (we != '0);
    if (e.is_write) begin
      m = ref_rd(w);
      for (int b = 0; b < 4; b++) if (we[b]) m[8*b +: 8] = din[8*b +: 8];
      ref_mem[int'(w)] = m;
      e.data = din; e.hs = 1;
    end else begin
      e.hs = (ref_line.exists(idx) && ref_line[idx] == w) ? 0 : 1;
      ref_line[idx] = w;
      e.data = ref_rd(w);
    end
    sb.push_back(e);
    dcache_re = rd; dcache_we = we; dcache_addr = addr; dcache_din = din;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (stall && cyc < 400);
    if (stall) chk("issue_timeout", cyc, 0);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    dcache_re = 1'b0; dcache_we = '0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int cyc = 0;
    idle(0);
    while (sb.size() != 0 && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    idle(1);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "global timeout");
  end

  initial begin
    int base;
    reset_n = 1'b0;
    dcache_re = 1'b0; dcache_we = '0; dcache_addr = '0; dcache_din = '0;
    ref_mem[32'h40] = 32'hDEADBEEF;  back_mem[32'h40] = 32'hDEADBEEF;
    ref_mem[32'h80] = 32'h11111111;  back_mem[32'h80] = 32'h11111111;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_dout", dcache_dout, 0);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_req_rw", mem_req_rw, 0);
    chk("rst_req_mask", mem_req_mask, 0);
    chk("rst_req_addr", mem_req_addr, 0);
    chk("rst_req_data", mem_req_data, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_stall", stall, 0);

    // Cold read miss, response 3 cycles after the handshake.
    lat_min = 3; lat_max = 3; delay_min = 0; delay_max = 0;
    issue(1, 4'b0000, 32'h100, '0);
    drain();

    // Back-to-back hits.
    repeat (3) issue(1, 4'b0000, 32'h100, '0);
    drain();

    // Partial write hit with ready held low, then read back the merge.
    delay_min = 4; delay_max = 4;
    issue(0, 4'b0011, 32'h100, 32'h0000CAFE);
    issue(1, 4'b0000, 32'h100, '0);
    drain();

    // Conflict eviction on index 0.
    delay_min = 0; delay_max = 2; lat_min = 1; lat_max = 3;
    issue(1, 4'b0000, 32'h200, '0);
    issue(1, 4'b0000, 32'h100, '0);
    drain();

    // Write miss allocates nothing.
    issue(0, 4'b1111, 32'h300, $urandom);
    issue(1, 4'b0000, 32'h300, '0);
    drain();

    // Reset while waiting for read data; the late response must be dropped.
    delay_min = 0; delay_max = 0; lat_min = 8; lat_max = 8;
    base = hs_count;
    issue(1, 4'b0000, 32'h100, '0);
    idle(0);
    for (int i = 0; i < 50 && hs_count == base; i++) begin @(posedge clk); #1; end
    chk("abort_read_issued", hs_count - base, 1);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_req_valid", mem_req_valid, 0);
    sb.delete();
    ref_line.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(10);
    lat_min = 1; lat_max = 2;
    issue(1, 4'b0000, 32'h100, '0);
    drain();

    // Randomized traffic over a small address set to force hits and conflicts.
    delay_min = 0; delay_max = 3; lat_min = 1; lat_max = 4;
    for (int n = 0; n < 400; n++) begin
      logic [29:0] w;
      logic [3:0] we;
      int op;
      w = 30'($urandom_range(3, 0) * 64 + $urandom_range(7, 0));
      op = int'($urandom_range(3, 0));
      we = 4'($urandom_range(15, 1));
      if (op < 2)       issue(1, 4'b0000, {w, 2'b00}, $urandom);
      else if (op == 2) issue(0, we, {w, 2'b00}, $urandom);
      else              issue(1, we, {w, 2'b00}, $urandom);
      if ($urandom_range(3, 0) == 0) idle(int'($urandom_range(2, 0)));
    end
    drain();
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
